link_ctrl: RTL and testbench
============================

Name: link_ctrl

Overview:
- Game-loop sequencer: the initiator side of the character state-strobe protocol.
- Generates the mutually exclusive strobes init, idle, reg_action, apply_action, draw_map and draw_char consumed by the character and map drawers, and consumes their done handshakes.
- Paces one game update per frame tick.
- Sits between top-level input/VGA plumbing and the link character, map renderer and collision detector.

Parameters:
FRAME_DIV, 833333, clock cycles per game frame (50 MHz / 60 Hz)
FRAME_W, 20, width of frame-divider counter
COLLIDE_CYCLES, 2, cycles allowed for collision_detector to settle after reg_action
TIMEOUT, 4095, max cycles to wait for any done signal before aborting the draw phase

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  level; game runs while high
map_done  in  1  map renderer finished (held high until draw_map drops)
draw_done  in  1  character drawer finished (held high until draw_char drops)
init  out  1  initialise character/map registers
idle  out  1  waiting for frame tick
draw_map  out  1  map renderer active (level)
reg_action  out  1  one-cycle strobe: latch user command
apply_action  out  1  one-cycle strobe: commit move using collision result
draw_char  out  1  character drawer active (level)
frame_count  out  8  completed frames, wraps 255->0
timeout_err  out  1  sticky; set when a done wait exceeds TIMEOUT

Behaviour:
- One clock, one always block for state/counters. reset is asynchronous and active-low; the async assert puts the FSM in S_RESET with all outputs 0, frame_count=0, timeout_err=0 and counters=0. Release is taken on the next clock edge.
- Outputs are Moore, decoded from a registered state. At most one of init/idle/reg_action/apply_action/draw_map/draw_char is high in any cycle.
- States and transitions:
  - S_RESET: all strobes 0. Goes to S_INIT when start=1.
  - S_INIT: init=1 for exactly 1 cycle, then S_IDLE.
  - S_IDLE: idle=1; frame divider counts. When divider == FRAME_DIV-1: divider clears and go to S_MAP. If start=0: go to S_RESET, divider cleared.
  - S_MAP: draw_map=1. Go to S_REG on the first cycle map_done=1.
  - S_REG: reg_action=1 for 1 cycle, then S_COLL.
  - S_COLL: all strobes 0 for COLLIDE_CYCLES cycles, then S_APPLY.
  - S_APPLY: apply_action=1 for 1 cycle, then S_CHAR.
  - S_CHAR: draw_char=1. On the first cycle draw_done=1: frame_count increments and go to S_IDLE.
- Done inputs are level-held by the responders and drop one cycle after their enable drops. The controller samples map_done only in S_MAP and draw_done only in S_CHAR; stale highs in other states are ignored.
- The divider keeps running only in S_IDLE. Frame tick latency from entering S_IDLE is FRAME_DIV cycles.
- Minimum frame (done returns in 1 cycle each): S_MAP 1 + REG 1 + COLL COLLIDE_CYCLES + APPLY 1 + CHAR 1 = COLLIDE_CYCLES+4 cycles.
- Timeout: a wait counter clears on entry to S_MAP and to S_CHAR and increments each cycle spent waiting. On reaching TIMEOUT:
  - set timeout_err (sticky until reset);
  - go to S_IDLE without incrementing frame_count.
- start dropping mid-frame: the current frame completes, then S_IDLE->S_RESET. Re-raising start reissues init.
- Simultaneous timeout and done in the same cycle: done wins (frame counted, no error).
- Async reset mid-draw: strobes drop immediately, without waiting for a clock edge.

Test Plan:
- Reset/start: hold reset=0 and 5 clocks, then release, start=1 -> init high exactly 1 cycle, then idle=1. All other strobes 0 throughout.
- Nominal frame (FRAME_DIV=8, COLLIDE_CYCLES=2), map_done after 3 cycles, draw_done after 256 cycles of draw_char:
  - idle=1 for 8 cycles;
  - draw_map=1 for 3 cycles;
  - reg_action 1 cycle, 2 silent cycles, apply_action 1 cycle;
  - draw_char=1 for 256 cycles;
  - frame_count 0->1, then back to idle.
- Stale done: draw_done held high while in S_IDLE and S_MAP -> ignored. draw_char still asserts for at least 1 cycle, and the frame ends on the first S_CHAR cycle.
- Timeout (TIMEOUT=16), map_done never asserted -> draw_map high 16 cycles, timeout_err=1, return to idle, frame_count unchanged. timeout_err stays 1 over the next good frame.
- Wrap: run 256 frames with fast dones -> frame_count returns to 0, no error.
- Mid-draw abort: assert reset=0 asynchronously during draw_char -> draw_char falls before the next clock edge, state S_RESET, frame_count=0.

Source files
------------

// File: rtl/link_ctrl_if.sv
// Strobe/done handshake bundle between the game-loop sequencer and its drawers.
// The master side is the sequencer; the slave side is the responder/plumbing.
interface link_ctrl_if;
    logic       start;
    logic       map_done;
    logic       draw_done;
    logic       init;
    logic       idle;
    logic       draw_map;
    logic       reg_action;
    logic       apply_action;
    logic       draw_char;
    logic [7:0] frame_count;
    logic       timeout_err;

    modport master (
        input  start, map_done, draw_done,
        output init, idle, draw_map, reg_action, apply_action, draw_char,
               frame_count, timeout_err
    );

    modport slave (
        output start, map_done, draw_done,
        input  init, idle, draw_map, reg_action, apply_action, draw_char,
               frame_count, timeout_err
    );
endinterface

// File: rtl/link_ctrl.sv
// Game-loop sequencer: paces one map/character update per frame tick and
// issues mutually exclusive strobes to the drawers, with done-wait timeout.
module link_ctrl #(
    parameter int unsigned FRAME_DIV      = 833333,
    parameter int unsigned FRAME_W        = 20,
    parameter int unsigned COLLIDE_CYCLES = 2,
    parameter int unsigned TIMEOUT        = 4095
) (
    input  logic          clock_i,
    input  logic          reset_i,
    link_ctrl_if.master   bus_if
);

    localparam int unsigned WAIT_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned COLL_W  = (COLLIDE_CYCLES > 1) ? $clog2(COLLIDE_CYCLES) : 1;
    localparam int unsigned COUNT_W = 8;

    typedef enum logic [2:0] {
        S_RESET,
        S_INIT,
        S_IDLE,
        S_MAP,
        S_REG,
        S_COLL,
        S_APPLY,
        S_CHAR
    } state_e;

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   div_q, div_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [COLL_W-1:0]    coll_q, coll_d;
    logic [COUNT_W-1:0]   frame_q, frame_d;
    logic                 terr_q, terr_d;

    logic init_q, idle_q, map_q, reg_q, apply_q, char_q;

    logic frame_tick;
    logic wait_expired;
    logic coll_last;

    assign frame_tick   = (div_q == FRAME_W'(FRAME_DIV - 1));
    assign wait_expired = (wait_q == WAIT_W'(TIMEOUT - 1));
    assign coll_last    = (coll_q == COLL_W'(COLLIDE_CYCLES - 1));

    // Next-state and counter update; done inputs only matter in their wait state,
    // and a done arriving on the expiry cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        wait_d  = wait_q;
        coll_d  = coll_q;
        frame_d = frame_q;
        terr_d  = terr_q;

        unique case (state_q)
            S_RESET: begin
                div_d = '0;
                if (bus_if.start) begin
                    state_d = S_INIT;
                end
            end

            S_INIT: begin
                state_d = S_IDLE;
            end

            S_IDLE: begin
                if (!bus_if.start) begin
                    div_d   = '0;
                    state_d = S_RESET;
                end else if (frame_tick) begin
                    div_d   = '0;
                    wait_d  = '0;
                    state_d = S_MAP;
                end else begin
                    div_d = div_q + FRAME_W'(1);
                end
            end

            S_MAP: begin
                if (bus_if.map_done) begin
                    state_d = S_REG;
                end else if (wait_expired) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            S_REG: begin
                coll_d  = '0;
                state_d = S_COLL;
            end

            S_COLL: begin
                if (coll_last) begin
                    state_d = S_APPLY;
                end else begin
                    coll_d = coll_q + COLL_W'(1);
                end
            end

            S_APPLY: begin
                wait_d  = '0;
                state_d = S_CHAR;
            end

            S_CHAR: begin
                if (bus_if.draw_done) begin
                    frame_d = frame_q + COUNT_W'(1);
                    state_d = S_IDLE;
                end else if (wait_expired) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    // Strobes are registered from the next state so they track state_q exactly
    // and clear asynchronously with reset.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_RESET;
            div_q   <= '0;
            wait_q  <= '0;
            coll_q  <= '0;
            frame_q <= '0;
            terr_q  <= 1'b0;
            init_q  <= 1'b0;
            idle_q  <= 1'b0;
            map_q   <= 1'b0;
            reg_q   <= 1'b0;
            apply_q <= 1'b0;
            char_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            wait_q  <= wait_d;
            coll_q  <= coll_d;
            frame_q <= frame_d;
            terr_q  <= terr_d;
            init_q  <= (state_d == S_INIT);
            idle_q  <= (state_d == S_IDLE);
            map_q   <= (state_d == S_MAP);
            reg_q   <= (state_d == S_REG);
            apply_q <= (state_d == S_APPLY);
            char_q  <= (state_d == S_CHAR);
        end
    end

    assign bus_if.init         = init_q;
    assign bus_if.idle         = idle_q;
    assign bus_if.draw_map     = map_q;
    assign bus_if.reg_action   = reg_q;
    assign bus_if.apply_action = apply_q;
    assign bus_if.draw_char    = char_q;
    assign bus_if.frame_count  = frame_q;
    assign bus_if.timeout_err  = terr_q;

endmodule

// File: tb/tb_link_ctrl.sv
// Directed bench for link_ctrl: two instances (long and short done timeout)
// with bench-side map/character responders driven from the main thread.
module tb_link_ctrl;

    localparam int W_INIT  = 0;
    localparam int W_IDLE  = 1;
    localparam int W_MAP   = 2;
    localparam int W_REG   = 3;
    localparam int W_APPLY = 4;
    localparam int W_CHAR  = 5;

    logic clk;
    logic ra;
    logic rb;

    int checks;
    int failures;
    int onehot_bad;

    int mlat_a, clat_a, mcnt_a, ccnt_a;
    int mlat_b, clat_b, mcnt_b, ccnt_b;
    logic dd_a, dd_b, stale_a;

    link_ctrl_if ifa ();
    link_ctrl_if ifb ();

    link_ctrl #(
        .FRAME_DIV(8), .FRAME_W(20), .COLLIDE_CYCLES(2), .TIMEOUT(4095)
    ) u_dut_a (
        .clock_i(clk),
        .reset_i(ra),
        .bus_if (ifa)
    );

    link_ctrl #(
        .FRAME_DIV(8), .FRAME_W(20), .COLLIDE_CYCLES(2), .TIMEOUT(16)
    ) u_dut_b (
        .clock_i(clk),
        .reset_i(rb),
        .bus_if (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic sel(input int d, input int w);
        logic v;
        v = 1'b0;
        if (d == 0) begin
            case (w)
                W_INIT:  v = ifa.init;
                W_IDLE:  v = ifa.idle;
                W_MAP:   v = ifa.draw_map;
                W_REG:   v = ifa.reg_action;
                W_APPLY: v = ifa.apply_action;
                default: v = ifa.draw_char;
            endcase
        end else begin
            case (w)
                W_INIT:  v = ifb.init;
                W_IDLE:  v = ifb.idle;
                W_MAP:   v = ifb.draw_map;
                W_REG:   v = ifb.reg_action;
                W_APPLY: v = ifb.apply_action;
                default: v = ifb.draw_char;
            endcase
        end
        return v;
    endfunction

    function automatic int nstrobes(input int d);
        int n;
        n = 0;
        for (int w = 0; w < 6; w++) begin
            if (sel(d, w) === 1'b1) n++;
        end
        return n;
    endfunction

    // Advance one clock, sample just after the edge, then update responders.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (nstrobes(0) > 1 || nstrobes(1) > 1) onehot_bad++;
        if (ifa.draw_map === 1'b1) begin
            mcnt_a++;
            if (mlat_a != 0 && mcnt_a >= mlat_a) ifa.map_done = 1'b1;
        end else begin
            mcnt_a = 0;
            ifa.map_done = 1'b0;
        end
        if (ifa.draw_char === 1'b1) begin
            ccnt_a++;
            if (clat_a != 0 && ccnt_a >= clat_a) dd_a = 1'b1;
        end else begin
            ccnt_a = 0;
            dd_a = 1'b0;
        end
        ifa.draw_done = dd_a | stale_a;
        if (ifb.draw_map === 1'b1) begin
            mcnt_b++;
            if (mlat_b != 0 && mcnt_b >= mlat_b) ifb.map_done = 1'b1;
        end else begin
            mcnt_b = 0;
            ifb.map_done = 1'b0;
        end
        if (ifb.draw_char === 1'b1) begin
            ccnt_b++;
            if (clat_b != 0 && ccnt_b >= clat_b) dd_b = 1'b1;
        end else begin
            ccnt_b = 0;
            dd_b = 1'b0;
        end
        ifb.draw_done = dd_b;
    endtask

    task automatic run_len(input int d, input int w, output int len);
        len = 0;
        while (sel(d, w) === 1'b1 && len < 5000) begin
            len++;
            cyc();
        end
    endtask

    task automatic run_silent(input int d, output int len);
        len = 0;
        while (nstrobes(d) == 0 && len < 64) begin
            len++;
            cyc();
        end
    endtask

    // Measures every phase of one frame, starting on the first idle cycle.
    task automatic run_frame(input int d, output int li, output int lm, output int lr,
                             output int ls, output int la, output int lc);
        run_len(d, W_IDLE, li);
        run_len(d, W_MAP, lm);
        run_len(d, W_REG, lr);
        run_silent(d, ls);
        run_len(d, W_APPLY, la);
        run_len(d, W_CHAR, lc);
    endtask

    task automatic test_reset();
        repeat (5) cyc();
        checks++;
        if (nstrobes(0) !== 0) begin
            failures++;
            $display("FAIL reset_strobes: got %0d high want 0", nstrobes(0));
        end
        checks++;
        if (ifa.frame_count !== 8'd0 || ifa.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs: got fc=%0d err=%b want 0/0", ifa.frame_count, ifa.timeout_err);
        end
        ra = 1'b1;
        ifa.start = 1'b1;
        cyc();
        checks++;
        if (ifa.init !== 1'b1 || nstrobes(0) !== 1) begin
            failures++;
            $display("FAIL reset_init: got init=%b n=%0d want 1/1", ifa.init, nstrobes(0));
        end
        cyc();
        checks++;
        if (ifa.init !== 1'b0 || ifa.idle !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle: got init=%b idle=%b want 0/1", ifa.init, ifa.idle);
        end
    endtask

    task automatic test_nominal();
        int li, lm, lr, ls, la, lc;
        mlat_a = 3;
        clat_a = 256;
        run_frame(0, li, lm, lr, ls, la, lc);
        checks++;
        if (li != 8 || lm != 3) begin
            failures++;
            $display("FAIL nominal_idle_map: got %0d/%0d want 8/3", li, lm);
        end
        checks++;
        if (lr != 1 || ls != 2 || la != 1) begin
            failures++;
            $display("FAIL nominal_reg_coll_apply: got %0d/%0d/%0d want 1/2/1", lr, ls, la);
        end
        checks++;
        if (lc != 256) begin
            failures++;
            $display("FAIL nominal_char: got %0d want 256", lc);
        end
        checks++;
        if (ifa.frame_count !== 8'd1 || ifa.idle !== 1'b1) begin
            failures++;
            $display("FAIL nominal_count: got fc=%0d idle=%b want 1/1", ifa.frame_count, ifa.idle);
        end
    endtask

    task automatic test_stale_done();
        int li, lm, lr, ls, la, lc;
        mlat_a = 1;
        clat_a = 1;
        stale_a = 1'b1;
        ifa.draw_done = 1'b1;
        run_frame(0, li, lm, lr, ls, la, lc);
        stale_a = 1'b0;
        checks++;
        if (li != 8 || lm != 1 || ls != 2) begin
            failures++;
            $display("FAIL stale_ignored: got idle=%0d map=%0d coll=%0d want 8/1/2", li, lm, ls);
        end
        checks++;
        if (lc != 1 || ifa.frame_count !== 8'd2) begin
            failures++;
            $display("FAIL stale_char: got len=%0d fc=%0d want 1/2", lc, ifa.frame_count);
        end
    endtask

    task automatic test_start_drop();
        int li, lm, lr, ls, la, lc;
        run_len(0, W_IDLE, li);
        ifa.start = 1'b0;
        run_len(0, W_MAP, lm);
        run_len(0, W_REG, lr);
        run_silent(0, ls);
        run_len(0, W_APPLY, la);
        run_len(0, W_CHAR, lc);
        checks++;
        if (lc != 1 || ifa.idle !== 1'b1 || ifa.frame_count !== 8'd3) begin
            failures++;
            $display("FAIL drop_completes: got char=%0d idle=%b fc=%0d want 1/1/3", lc, ifa.idle, ifa.frame_count);
        end
        cyc();
        cyc();
        checks++;
        if (nstrobes(0) !== 0) begin
            failures++;
            $display("FAIL drop_to_reset: got %0d strobes want 0", nstrobes(0));
        end
        ifa.start = 1'b1;
        cyc();
        checks++;
        if (ifa.init !== 1'b1) begin
            failures++;
            $display("FAIL drop_reinit: got init=%b want 1", ifa.init);
        end
        cyc();
    endtask

    task automatic test_abort();
        int li, lm, lr, ls, la;
        clat_a = 256;
        run_len(0, W_IDLE, li);
        run_len(0, W_MAP, lm);
        run_len(0, W_REG, lr);
        run_silent(0, ls);
        run_len(0, W_APPLY, la);
        repeat (3) cyc();
        checks++;
        if (ifa.draw_char !== 1'b1 || ifa.frame_count !== 8'd3) begin
            failures++;
            $display("FAIL abort_pre: got char=%b fc=%0d want 1/3", ifa.draw_char, ifa.frame_count);
        end
        #3;
        ra = 1'b0;
        #1;
        checks++;
        if (ifa.draw_char !== 1'b0 || nstrobes(0) !== 0 || ifa.frame_count !== 8'd0) begin
            failures++;
            $display("FAIL abort_async: got char=%b n=%0d fc=%0d want 0/0/0", ifa.draw_char, nstrobes(0), ifa.frame_count);
        end
        cyc();
        cyc();
        ra = 1'b1;
        cyc();
        checks++;
        if (ifa.init !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart: got init=%b want 1", ifa.init);
        end
        cyc();
    endtask

    task automatic test_wrap();
        int li, lm, lr, ls, la, lc;
        int wrap_bad;
        wrap_bad = 0;
        mlat_a = 1;
        clat_a = 1;
        for (int i = 0; i < 256; i++) begin
            run_frame(0, li, lm, lr, ls, la, lc);
            if (li != 8 || lm != 1 || lr != 1 || ls != 2 || la != 1 || lc != 1) wrap_bad++;
            if (i == 254) begin
                checks++;
                if (ifa.frame_count !== 8'd255) begin
                    failures++;
                    $display("FAIL wrap_255: got %0d want 255", ifa.frame_count);
                end
            end
        end
        checks++;
        if (ifa.frame_count !== 8'd0 || ifa.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL wrap_zero: got fc=%0d err=%b want 0/0", ifa.frame_count, ifa.timeout_err);
        end
        checks++;
        if (wrap_bad != 0) begin
            failures++;
            $display("FAIL wrap_frames: got %0d bad frames want 0", wrap_bad);
        end
    endtask

    task automatic test_timeout();
        int li, lm, lr, ls, la, lc;
        rb = 1'b1;
        ifb.start = 1'b1;
        mlat_b = 0;
        clat_b = 1;
        cyc();
        cyc();
        run_len(1, W_IDLE, li);
        run_len(1, W_MAP, lm);
        checks++;
        if (li != 8 || lm != 16) begin
            failures++;
            $display("FAIL timeout_len: got idle=%0d map=%0d want 8/16", li, lm);
        end
        checks++;
        if (ifb.idle !== 1'b1 || ifb.timeout_err !== 1'b1 || ifb.frame_count !== 8'd0) begin
            failures++;
            $display("FAIL timeout_flag: got idle=%b err=%b fc=%0d want 1/1/0", ifb.idle, ifb.timeout_err, ifb.frame_count);
        end
        mlat_b = 1;
        run_frame(1, li, lm, lr, ls, la, lc);
        checks++;
        if (lm != 1 || lc != 1 || ifb.frame_count !== 8'd1 || ifb.timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: got map=%0d char=%0d fc=%0d err=%b want 1/1/1/1", lm, lc, ifb.frame_count, ifb.timeout_err);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        onehot_bad = 0;
        mlat_a = 1; clat_a = 1; mcnt_a = 0; ccnt_a = 0;
        mlat_b = 1; clat_b = 1; mcnt_b = 0; ccnt_b = 0;
        dd_a = 1'b0; dd_b = 1'b0; stale_a = 1'b0;
        ra = 1'b0;
        rb = 1'b0;
        ifa.start = 1'b0; ifa.map_done = 1'b0; ifa.draw_done = 1'b0;
        ifb.start = 1'b0; ifb.map_done = 1'b0; ifb.draw_done = 1'b0;

        test_reset();
        test_nominal();
        test_stale_done();
        test_start_drop();
        test_abort();
        test_wrap();
        test_timeout();

        checks++;
        if (onehot_bad != 0) begin
            failures++;
            $display("FAIL onehot: got %0d cycles with multiple strobes want 0", onehot_bad);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
